// File: rtl/sample_timer_ctrl.sv
// Bit-timing sequencer for the serial receiver: drives an external flex counter through a
// half-bit delay to mid-bit, then NUM_BITS full-bit periods, strobing once per bit.
module sample_timer_ctrl #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_BITS     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  input  logic                    cnt_rollover_flag,
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
  output logic                    sample_strobe,
  output logic                    packet_done,
  output logic                    cfg_err,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALF   = 3'd1,
    RESYNC = 3'd2,
    BIT    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic                    period_ok;

  assign period_ok = (bit_period >= NUM_CNT_BITS'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Abort outranks a coincident rollover flag in every active state.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (start && period_ok) begin
          state_d   = HALF;
          period_d  = bit_period;
          bit_idx_d = '0;
        end
      end
      HALF: begin
        if (abort)                  state_d = IDLE;
        else if (cnt_rollover_flag) state_d = RESYNC;
      end
      RESYNC: begin
        state_d = abort ? IDLE : BIT;
      end
      BIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_rollover_flag) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(NUM_BITS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter controls depend only on state and latched period; pulses are suppressed
  // in an abort cycle so a cancelled packet never reports a sample or completion.
  always_comb begin
    cnt_clear        = 1'b1;
    cnt_enable       = 1'b0;
    cnt_rollover_val = '0;
    sample_strobe    = 1'b0;
    packet_done      = 1'b0;
    cfg_err          = 1'b0;
    busy             = 1'b1;
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        cfg_err = start && !period_ok;
      end
      HALF: begin
        cnt_clear        = 1'b0;
        cnt_enable       = 1'b1;
        cnt_rollover_val = period_q >> 1;
      end
      RESYNC: begin
        cnt_rollover_val = period_q;
      end
      BIT: begin
        cnt_clear        = 1'b0;
        cnt_enable       = 1'b1;
        cnt_rollover_val = period_q;
        sample_strobe    = cnt_rollover_flag && !abort;
      end
      DONE: begin
        cnt_rollover_val = period_q;
        packet_done      = !abort;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sample_timer_ctrl.sv
// Directed bench for sample_timer_ctrl with a behavioural flex counter on the cnt_* ports.
// Cycle 0 of each scenario is the cycle in which start is presented.
module tb_sample_timer_ctrl;

  localparam int CW   = 4;
  localparam int NB   = 9;
  localparam int HIST = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] bit_period;
  logic          cnt_rollover_flag;
  logic          cnt_clear;
  logic          cnt_enable;
  logic [CW-1:0] cnt_rollover_val;
  logic          sample_strobe;
  logic          packet_done;
  logic          cfg_err;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int t0       = 0;

  int   strb_q[$];
  int   done_q[$];
  logic [31:0] exp_q[$];
  logic busy_h[HIST];
  logic clr_h[HIST];
  logic en_h[HIST];
  logic cfg_h[HIST];

  sample_timer_ctrl #(.NUM_CNT_BITS(CW), .NUM_BITS(NB)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .bit_period        (bit_period),
    .cnt_rollover_flag (cnt_rollover_flag),
    .cnt_clear         (cnt_clear),
    .cnt_enable        (cnt_enable),
    .cnt_rollover_val  (cnt_rollover_val),
    .sample_strobe     (sample_strobe),
    .packet_done       (packet_done),
    .cfg_err           (cfg_err),
    .busy              (busy)
  );

  // Clock / reset block and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flex counter model: flag high in cycle c+R, c+2R, ... when enabled from cycle c.
  logic [CW-1:0] cnt_q;
  always @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (cnt_clear)   cnt_q <= '0;
    else if (cnt_enable)  cnt_q <= (cnt_q == cnt_rollover_val) ? CW'(1) : cnt_q + CW'(1);
  end
  assign cnt_rollover_flag = (cnt_q == cnt_rollover_val) && (cnt_q != '0);

  // Monitor: record pulse times and per-cycle levels relative to t0
  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (sample_strobe) strb_q.push_back(r);
    if (packet_done)   done_q.push_back(r);
    if (r >= 0 && r < HIST) begin
      busy_h[r] = busy;
      clr_h[r]  = cnt_clear;
      en_h[r]   = cnt_enable;
      cfg_h[r]  = cfg_err;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present start with period p in a fresh cycle; returns at cycle 1 + #1.
  task automatic begin_packet(input int p, input bit hold);
    @(posedge clk);
    #1;
    t0 = cyc;
    strb_q.delete();
    done_q.delete();
    for (int i = 0; i < HIST; i++) begin
      busy_h[i] = 1'bx;
      clr_h[i]  = 1'bx;
      en_h[i]   = 1'bx;
      cfg_h[i]  = 1'bx;
    end
    start      = 1'b1;
    bit_period = CW'(p);
    @(posedge clk);
    #1;
    if (!hold) begin
      start      = 1'b0;
      bit_period = CW'($urandom_range(0, 15));
    end
  endtask

  // Compare n observed strobes from index base against first, first+p, ...
  task automatic check_train(input string tag, input int base, input int first,
                             input int p, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(32'(first + k * p));
    for (int k = 0; k < n; k++) begin
      if (base + k < strb_q.size()) check(tag, strb_q[base + k], int'(exp_q[k]));
      else                          check(tag, -1, int'(exp_q[k]));
    end
  endtask

  task automatic check_packet(input string tag, input int p);
    int h;
    h = p >> 1;
    begin_packet(p, 1'b0);
    repeat (h + 8 + 9 * p) @(negedge clk);
    check({tag, "_busy0"}, busy_h[0], 0);
    check({tag, "_busy1"}, busy_h[1], 1);
    check({tag, "_nstrobe"}, strb_q.size(), NB);
    check_train({tag, "_strobe"}, 0, h + 3 + p, p, NB);
    check({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, "_done_t"}, done_q[0], h + 4 + NB * p);
    check({tag, "_busy_last"}, busy_h[h + 4 + NB * p], 1);
    check({tag, "_busy_fall"}, busy_h[h + 5 + NB * p], 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    bit_period = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clear",  cnt_clear, 1);
    check("rst_enable", cnt_enable, 0);
    check("rst_rval",   cnt_rollover_val, 0);
    check("rst_busy",   busy, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_done",   packet_done, 0);
    check("rst_cfgerr", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;

    check_packet("p10", 10);
    check_packet("p2", 2);
    check_packet("p15", 15);

    // Abort mid-BIT at cycle 40, then start+abort together in IDLE at cycle 45 (P=3)
    begin_packet(10, 1'b0);
    repeat (39) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start      = 1'b1;
    abort      = 1'b1;
    bit_period = CW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_nstrobe", strb_q.size(), 12);
    check_train("abort_pre", 0, 18, 10, 3);
    check("abort_busy40", busy_h[40], 1);
    check("abort_busy41", busy_h[41], 0);
    check("abort_clear41", clr_h[41], 1);
    check("abort_en41", en_h[41], 0);
    check("abort_restart46", busy_h[46], 1);
    check_train("abort_post", 3, 52, 3, NB);
    check("abort_ndone", done_q.size(), 1);
    if (done_q.size() > 0) check("abort_done_t", done_q[0], 77);

    // Start held high across a packet (P=4, H=2): re-accepted in the IDLE cycle after done
    begin_packet(4, 1'b1);
    repeat (49) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (46) @(negedge clk);
    check("hold_nstrobe", strb_q.size(), 2 * NB);
    check_train("hold_pkt1", 0, 9, 4, NB);
    check_train("hold_pkt2", NB, 52, 4, NB);
    check("hold_ndone", done_q.size(), 2);
    if (done_q.size() > 1) begin
      check("hold_done1", done_q[0], 42);
      check("hold_done2", done_q[1], 85);
    end
    check("hold_idle43", busy_h[43], 0);
    check("hold_busy44", busy_h[44], 1);
    check("hold_idle86", busy_h[86], 0);

    // Rejected periods
    for (int p = 0; p < 2; p++) begin
      int en_cnt;
      begin_packet(p, 1'b0);
      repeat (4) @(negedge clk);
      en_cnt = 0;
      for (int i = 0; i < 4; i++) en_cnt += int'(en_h[i]);
      check($sformatf("cfg%0d_err0", p), cfg_h[0], 1);
      check($sformatf("cfg%0d_err1", p), cfg_h[1], 0);
      check($sformatf("cfg%0d_busy1", p), busy_h[1], 0);
      check($sformatf("cfg%0d_busy3", p), busy_h[3], 0);
      check($sformatf("cfg%0d_enable", p), en_cnt, 0);
      check($sformatf("cfg%0d_nstrobe", p), strb_q.size(), 0);
    end

    // Asynchronous reset between edges in the middle of BIT
    begin_packet(10, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    check("prerst_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy",   busy, 0);
    check("arst_clear",  cnt_clear, 1);
    check("arst_enable", cnt_enable, 0);
    check("arst_strobe", sample_strobe, 0);
    check("arst_done",   packet_done, 0);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    check_packet("post_rst", 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
